// File: rtl/poly_mem_fill_ctrl_pkg.sv
// ============================================================================
// Module : poly_pkg
// Brief  : Shared state encoding and default sizes for the polynomial RAM
//          controllers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package poly_pkg;

    localparam int COEF_W_Q   = 13;
    localparam int N_COEF_DEF = 761;
    localparam int ADDR_W_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_FILL     = 2'd2,
        ST_DONE     = 2'd3
    } poly_state_e;

endpackage

`default_nettype wire

// File: rtl/poly_mem_fill_ctrl_if.sv
// ============================================================================
// Module : poly_mem_fill_ctrl_if
// Brief  : RAM write-port bundle between a fill controller and the port mux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface poly_mem_fill_ctrl_if
    import poly_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int COEF_W = COEF_W_Q
);
    logic              mem_req;
    logic              mem_we;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [COEF_W-1:0] mem_wdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_gnt);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_gnt);
endinterface

`default_nettype wire

// File: rtl/poly_addr_cnt.sv
// ============================================================================
// Module : poly_addr_cnt
// Brief  : Loadable, enabled address up-counter that flags the terminal address.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module poly_addr_cnt
    import poly_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_load,
    input  wire logic              i_en,
    input  wire logic [ADDR_W-1:0] i_start,
    input  wire logic [ADDR_W-1:0] i_end,
    output logic      [ADDR_W-1:0] o_addr,
    output logic                   o_last
);
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_end;

    // Counting stops on the terminal address so it never runs past the range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_end <= '0;
        end else if (i_load) begin
            r_cnt <= i_start;
            r_end <= i_end;
        end else if (i_en && !o_last) begin
            r_cnt <= r_cnt + ADDR_W'(1);
        end
    end

    assign o_addr = r_cnt;
    assign o_last = (r_cnt == r_end);

endmodule

`default_nettype wire

// File: rtl/poly_mem_fill_ctrl.sv
// ============================================================================
// Module : poly_mem_fill_ctrl
// Brief  : Writes a constant coefficient over an inclusive RAM address range.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module poly_mem_fill_ctrl
    import poly_pkg::*;
#(
    parameter int COEF_W = COEF_W_Q,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_COEF = N_COEF_DEF
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic              abort,
    input  wire logic [ADDR_W-1:0] start_addr,
    input  wire logic [ADDR_W-1:0] end_addr,
    input  wire logic [COEF_W-1:0] fill_val,
    poly_mem_fill_ctrl_if.master   mem,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    poly_state_e       r_state;
    poly_state_e       w_next;
    logic [COEF_W-1:0] r_wdata;
    logic              r_err;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;
    logic              w_range_ok;
    logic              w_accept;
    logic              w_req;
    logic              w_we;

    assign w_range_ok = (start_addr <= end_addr) && (int'(end_addr) < N_COEF);
    assign w_accept   = (r_state == ST_IDLE) && start && w_range_ok;

    poly_addr_cnt #(
        .ADDR_W (ADDR_W)
    ) u_addr_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_en    ((r_state == ST_FILL) && w_we),
        .i_start (start_addr),
        .i_end   (end_addr),
        .o_addr  (w_addr),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Rejected ranges are reported through the DONE pulse, so the flag lives until then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_wdata <= fill_val;
        end else if ((r_state == ST_IDLE) && start) begin
            r_err   <= 1'b1;
        end else if (r_state == ST_DONE) begin
            r_err   <= 1'b0;
        end
    end

    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        w_we   = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = w_range_ok ? ST_WAIT_GNT : ST_DONE;
                end
            end
            ST_WAIT_GNT: begin
                w_req = 1'b1;
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (mem.mem_gnt) begin
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                w_req = 1'b1;
                w_we  = mem.mem_gnt && !abort;
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_we && w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                err    = r_err;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign mem.mem_req   = w_req;
    assign mem.mem_we    = w_we;
    assign mem.mem_addr  = w_addr;
    assign mem.mem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_poly_mem_fill_ctrl.sv
// ============================================================================
// Module : tb_poly_mem_fill_ctrl
// Brief  : Self-checking bench for poly_mem_fill_ctrl against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_poly_mem_fill_ctrl;

    localparam int AW = 11;
    localparam int CW = 13;
    localparam int NC = 761;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic [CW-1:0] fill_val = '0;
    logic          busy, done, err;

    poly_mem_fill_ctrl_if #(.ADDR_W(AW), .COEF_W(CW)) mif ();

    poly_mem_fill_ctrl #(.COEF_W(CW), .ADDR_W(AW), .N_COEF(NC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .fill_val   (fill_val),
        .mem        (mif),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: pending addresses in a queue, plus a few phase flags.
    int          m_q[$];
    logic [CW-1:0] m_val;
    bit          m_active, m_granted, m_done_due, m_err_due;

    int n_we, n_req, n_done, first_we_cyc, last_we_cyc, done_cyc, done_err;

    always @(negedge clk) begin
        bit exp_we;
        if (!rst_n) begin
            m_q.delete();
            m_active = 0; m_granted = 0; m_done_due = 0; m_err_due = 0;
        end
        exp_we = m_active && m_granted && mif.mem_gnt && !abort;
        chk("busy",    int'(busy),        int'(m_active || m_done_due));
        chk("mem_req", int'(mif.mem_req), int'(m_active));
        chk("mem_we",  int'(mif.mem_we),  int'(exp_we));
        chk("done",    int'(done),        int'(m_done_due));
        chk("err",     int'(err),         int'(m_done_due && m_err_due));
        if (exp_we && mif.mem_we) begin
            chk("mem_addr",  int'(mif.mem_addr),  m_q[0]);
            chk("mem_wdata", int'(mif.mem_wdata), int'(m_val));
        end
        if (mif.mem_we) begin
            if (n_we == 0) first_we_cyc = cyc;
            last_we_cyc = cyc;
            n_we++;
        end
        if (mif.mem_req) n_req++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
            done_err = int'(err);
        end
        if (rst_n) begin
            if (m_done_due) begin
                m_done_due = 0;
            end else if (!m_active) begin
                if (start) begin
                    if (start_addr <= end_addr && int'(end_addr) < NC) begin
                        for (int a = int'(start_addr); a <= int'(end_addr); a++) m_q.push_back(a);
                        m_val = fill_val;
                        m_active = 1;
                        m_granted = 0;
                    end else begin
                        m_done_due = 1;
                        m_err_due = 1;
                    end
                end
            end else if (abort) begin
                m_active = 0;
                m_q.delete();
            end else if (!m_granted) begin
                if (mif.mem_gnt) m_granted = 1;
            end else if (mif.mem_gnt) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_active = 0;
                    m_done_due = 1;
                    m_err_due = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_we = 0; n_req = 0; n_done = 0;
        first_we_cyc = -1; last_we_cyc = -1; done_cyc = -1; done_err = -1;
    endtask

    // gmode: 0 gnt held, 1 random gnt, 2 gnt low in relative cycles 4..6.
    // abort_addr >= 0 aborts at that address; -2 aborts randomly.
    // noise_at >= 0 pulses a second start at that cycle; -2 pulses randomly.
    task automatic run_op(input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                          input logic [CW-1:0] v, input int gmode, input int abort_addr,
                          input int noise_at, input int budget,
                          output int s_cyc, output int end_cyc);
        int rel;
        clear_stats();
        start_addr = sa; end_addr = ea; fill_val = v;
        mif.mem_gnt = (gmode == 1) ? ($urandom_range(0, 9) < 7) : 1'b1;
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
        end_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                end_cyc = cyc;
                break;
            end
            rel = cyc - s_cyc;
            case (gmode)
                0:       mif.mem_gnt = 1'b1;
                1:       mif.mem_gnt = ($urandom_range(0, 9) < 7);
                default: mif.mem_gnt = !(rel >= 4 && rel <= 6);
            endcase
            if (abort_addr >= 0)
                abort = mif.mem_req && (int'(mif.mem_addr) == abort_addr);
            else if (abort_addr == -2)
                abort = ($urandom_range(0, 99) < 3);
            else
                abort = 1'b0;
            if (rel == noise_at || (noise_at == -2 && $urandom_range(0, 99) < 5)) begin
                start = 1'b1;
                start_addr = AW'($urandom_range(0, NC - 1));
                end_addr = AW'($urandom_range(0, NC - 1));
                fill_val = CW'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        abort = 1'b0;
        start = 1'b0;
        chk("op_finished", int'(busy), 0);
    endtask

    initial begin
        int s, e;
        logic [AW-1:0] ra, rb;
        mif.mem_gnt = 1'b0;
        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_req",  int'(mif.mem_req), 0);
        chk("rst_addr", int'(mif.mem_addr), 0);
        chk("rst_wdata", int'(mif.mem_wdata), 0);
        chk("rst_done", int'(done), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Full clear
        run_op(11'd0, 11'd760, 13'd0, 0, -1, -1, 900, s, e);
        chk("t1_writes", n_we, 761);
        chk("t1_first_we", first_we_cyc - s, 2);
        chk("t1_last_we", last_we_cyc - s, 762);
        chk("t1_done_cyc", done_cyc - s, 763);
        chk("t1_done_err", done_err, 0);
        chk("t1_idle_cyc", e - s, 764);

        // Grant stall
        run_op(11'd10, 11'd14, 13'h1ABC, 2, -1, -1, 60, s, e);
        chk("t2_writes", n_we, 5);
        chk("t2_last_we", last_we_cyc - s, 9);
        chk("t2_done_after_last", done_cyc - last_we_cyc, 1);

        // Invalid ranges
        run_op(11'd20, 11'd5, 13'd7, 0, -1, -1, 10, s, e);
        chk("t3a_done_cyc", done_cyc - s, 1);
        chk("t3a_err", done_err, 1);
        chk("t3a_req", n_req, 0);
        chk("t3a_we", n_we, 0);
        run_op(11'd0, 11'd761, 13'd7, 0, -1, -1, 10, s, e);
        chk("t3b_done_cyc", done_cyc - s, 1);
        chk("t3b_err", done_err, 1);
        chk("t3b_req", n_req, 0);

        // Abort at address 40
        run_op(11'd0, 11'd100, 13'd99, 0, 40, -1, 200, s, e);
        chk("t4_writes", n_we, 40);
        chk("t4_last_addr_cyc", last_we_cyc - s, 41);
        chk("t4_done", n_done, 0);

        // Start while busy
        run_op(11'd200, 11'd230, 13'd5, 0, -1, 10, 100, s, e);
        chk("t6_writes", n_we, 31);
        chk("t6_done", n_done, 1);

        // Asynchronous reset in the middle of a fill
        clear_stats();
        start_addr = 11'd0; end_addr = 11'd100; fill_val = 13'h0777;
        mif.mem_gnt = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (mif.mem_we && mif.mem_addr == 11'd50) break;
            tick();
        end
        chk("t5_reached_50", int'(mif.mem_addr), 50);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_req", int'(mif.mem_req), 0);
        chk("t5_we", int'(mif.mem_we), 0);
        chk("t5_addr", int'(mif.mem_addr), 0);
        chk("t5_wdata", int'(mif.mem_wdata), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        run_op(11'd3, 11'd3, 13'd42, 0, -1, -1, 20, s, e);
        chk("t5_single_writes", n_we, 1);
        chk("t5_single_done", n_done, 1);

        // Randomized operations
        for (int k = 0; k < 30; k++) begin
            ra = AW'($urandom_range(0, NC - 1));
            rb = AW'(int'(ra) + $urandom_range(0, 23));
            if ($urandom_range(0, 9) == 0) begin
                rb = ra;
                ra = AW'($urandom_range(int'(rb), 2047));
            end
            run_op(ra, rb, CW'($urandom), 1, ($urandom_range(0, 3) == 0) ? -2 : -1,
                   -2, 400, s, e);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
